// File: rtl/idli_decode_q_m.sv
// idli_decode_q_m: serial instruction decoder with a decoded-instruction queue.
// Assembles 16b encodings from BEAT_W-bit beats, decodes on the completing
// beat and queues the result in a DEPTH-entry FIFO drained with valid/ready.
// Optional feature macro: IDLI_DCD_FLUSH_EN (adds i_dcd_flush).

package idli_pkg;

    typedef enum logic [1:0] {
        AluOpAdd = 2'd0,
        AluOpAnd = 2'd1,
        AluOpOr  = 2'd2,
        AluOpXor = 2'd3
    } alu_op_t;

    typedef struct packed {
        logic [1:0] op_p;
        logic [1:0] op_q;
        logic [2:0] op_a;
        logic [2:0] op_b;
        logic [2:0] op_c;
        alu_op_t    alu_op;
    } instr_t;

endpackage

module idli_decode_q_m
    import idli_pkg::*;
#(
    parameter int unsigned BEAT_W = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       i_dcd_gck,
    input  logic                       i_dcd_rst,
    input  logic [BEAT_W-1:0]          i_dcd_enc,
    input  logic                       i_dcd_enc_vld,
    output logic                       o_dcd_enc_rdy,
    output instr_t                     o_dcd_instr,
    output logic                       o_dcd_instr_vld,
    input  logic                       i_dcd_instr_rdy,
`ifdef IDLI_DCD_FLUSH_EN
    input  logic                       i_dcd_flush,
`endif
    output logic [$clog2(DEPTH+1)-1:0] o_dcd_lvl
);

    localparam int unsigned BEATS = 16 / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned ASM_W = 16 - BEAT_W;

    typedef enum logic [0:0] {StIdle, StAsm} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    instr_t             mem_q [DEPTH];

    logic               flush;
    logic               beat_acc;
    logic               last_beat;
    logic               push;
    logic               pop;
    logic [15:0]        enc;
    logic [1:0]         grp;
    logic [2:0]         subop;
    instr_t             instr_new;

`ifdef IDLI_DCD_FLUSH_EN
    assign flush = i_dcd_flush;
`else
    assign flush = 1'b0;
`endif

    assign o_dcd_enc_rdy   = (lvl_q != LVL_W'(DEPTH));
    assign o_dcd_instr_vld = (lvl_q != '0);
    assign o_dcd_lvl       = lvl_q;
    assign o_dcd_instr     = mem_q[rd_ptr_q];

    assign beat_acc  = i_dcd_enc_vld & o_dcd_enc_rdy;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign push      = beat_acc & last_beat;
    assign pop       = o_dcd_instr_vld & i_dcd_instr_rdy;

    // Completing beat is joined combinationally onto the assembled prefix.
    if (BEAT_W == 16) begin : g_no_asm
        assign enc = i_dcd_enc;
    end else begin : g_asm
        logic [ASM_W-1:0] asm_q;

        // Shift accepted beats into the assembly register, MSB-first.
        always_ff @(posedge i_dcd_gck) begin
            if (i_dcd_rst || flush) begin
                asm_q <= '0;
            end else if (beat_acc) begin
                asm_q <= enc[ASM_W-1:0];
            end
        end

        assign enc = {asm_q, i_dcd_enc};
    end

    // Assembly state and beat counter registers.
    always_ff @(posedge i_dcd_gck) begin
        if (i_dcd_rst || flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Assembly next state: advance on accepted beats, wrap on the completing beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (beat_acc) begin
            if (last_beat) begin
                cnt_d   = '0;
                state_d = StIdle;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = StAsm;
            end
        end
    end

    // Field extraction and ALU-op decode of the complete encoding.
    always_comb begin
        grp              = enc[13:12];
        subop            = enc[11:9];
        instr_new.op_p   = enc[15:14];
        instr_new.op_q   = enc[10:9];
        instr_new.op_a   = enc[8:6];
        instr_new.op_b   = enc[5:3];
        instr_new.op_c   = enc[2:0];
        instr_new.alu_op = AluOpAdd;
        if (grp == 2'b10) begin
            case (subop)
                3'b010, 3'b011: instr_new.alu_op = AluOpAnd;
                3'b100:         instr_new.alu_op = AluOpOr;
                3'b101:         instr_new.alu_op = AluOpXor;
                default:        instr_new.alu_op = AluOpAdd;
            endcase
        end
    end

    // FIFO storage; contents need no reset since lvl gates visibility.
    always_ff @(posedge i_dcd_gck) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr_new;
        end
    end

    // Occupancy next value: simultaneous push and pop cancel.
    always_comb begin
        lvl_d = lvl_q;
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    // FIFO pointers and level; explicit wrap handles non-power-of-2 DEPTH.
    always_ff @(posedge i_dcd_gck) begin
        if (i_dcd_rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: doc/idli_decode_q_m.md
# idli_decode_q_m

Parametrised serial instruction decoder with an output queue. It accepts the 16b instruction encoding from the SQI fetch path as BEAT_W-bit beats and assembles the full encoding. It decodes the fields on the completing beat and pushes the decoded `instr_t` into a DEPTH-entry FIFO, which presents instructions to the backend with valid/ready. Unlike the fixed 4b decoder, it tolerates gaps between beats and applies backpressure to fetch.

## Interface
- BEAT_W, 4, bits per fetch beat; legal values 1, 2, 4, 8, 16; BEATS = 16/BEAT_W
- DEPTH, 2, decoded-instruction FIFO entries; ≥1, any integer
- i_dcd_gck  in  1  clock
- i_dcd_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_dcd_enc  in  BEAT_W  encoding beat; first beat carries enc[15:16-BEAT_W], MSB-first
- i_dcd_enc_vld  in  1  beat valid
- o_dcd_enc_rdy  out  1  beat accepted when vld & rdy
- o_dcd_instr  out  instr_t  head-of-FIFO decoded instruction (idli_pkg)
- o_dcd_instr_vld  out  1  FIFO non-empty
- i_dcd_instr_rdy  in  1  backend pops head when vld & rdy
- o_dcd_lvl  out  $clog2(DEPTH+1)  FIFO occupancy
- i_dcd_flush  in  1  present only with IDLI_DCD_FLUSH_EN

## Operation
- Beat counter `cnt` in 0..BEATS-1 advances on each accepted beat. It wraps to 0 on the completing beat (cnt==BEATS-1). Cycles without a beat hold state.
- Beats shift into a 16-BEAT_W bit assembly register. The completing beat is concatenated combinationally: enc = {asm, i_dcd_enc}. With BEAT_W=16, every accepted beat completes.
- Field extraction uses fixed positions, independent of group:
  - op_p=enc[15:14], op_q=enc[10:9]
  - op_a={enc[8],enc[7:6]}, op_b={enc[5:4],enc[3]}, op_c=enc[2:0]
- Group grp=enc[13:12]; subop s=enc[11:9]. alu_op is decoded as follows:
  - grp 00, 01, 11: ADD
  - grp 10 with s=01x: AND
  - grp 10 with s=100: OR
  - grp 10 with s=101: XOR
  - grp 10, any other s: ADD
- The completing beat pushes the decoded instr_t into the FIFO tail. Pop occurs on o_dcd_instr_vld & i_dcd_instr_rdy.
- o_dcd_enc_rdy = (lvl != DEPTH), from registered state only; there is no combinational path from i_dcd_instr_rdy. During assembly there are no pushes, so rdy cannot drop mid-instruction except by reaching DEPTH, which is only possible at a completion.
- Push and pop in the same cycle leave lvl unchanged; the head advances and the tail writes.
- FIFO pointers wrap modulo DEPTH. Non-power-of-2 DEPTH must wrap explicitly.
- State machine (assembly): IDLE (cnt==0) → ASM (0<cnt<BEATS) on the first accepted beat → IDLE on the completing beat. For BEATS=1, the block stays in IDLE.

## Timing
- Reset values: cnt=0, lvl=0, o_dcd_instr_vld=0, o_dcd_enc_rdy=1 (DEPTH≥1), o_dcd_lvl=0. o_dcd_instr is don't-care while vld=0 and has no reset.
- Latency: completing beat accepted at edge t → o_dcd_instr_vld=1 from cycle t+1 when the FIFO was empty.
- Throughput: one instruction per BEATS cycles sustained, with the FIFO drained each cycle.
- Reset asserted mid-assembly discards the partial encoding and all FIFO contents. A beat presented in the reset cycle is ignored.
- o_dcd_enc_rdy deasserts the cycle after lvl reaches DEPTH and reasserts the cycle after a pop.

## Configuration
- IDLI_DCD_FLUSH_EN defined: adds port i_dcd_flush, synchronous, priority below reset. A flush cycle clears cnt, assembly and FIFO (lvl=0, vld=0 next cycle). A beat or pop in the same cycle is discarded or ignored. Used for branch redirect.
- IDLI_DCD_FLUSH_EN undefined: the port is absent. Only i_dcd_rst clears state.

## Test plan
- BEAT_W=4, beats 0x2,0x4,0xA,0xB back-to-back, rdy=1 → one cycle after the 4th beat: vld=1 with p=0, q=2, a=2, b=5, c=3, alu_op=AND.
- BEAT_W=8, beats 0x6A then 0x00 with 3 idle cycles between → single instr: p=1, alu_op=XOR, a=0, c=0. No output before the 2nd beat.
- DEPTH=2, BEAT_W=16, instr_rdy=0, enc_vld=1 continuous → two pushes, lvl=2, enc_rdy=0. Raising instr_rdy for 1 cycle → lvl=1 and enc_rdy=1 the next cycle, with FIFO order preserved.
- BEAT_W=4, reset after 2 beats, then beats 0x3,0x0,0x0,0x0 → one instr with grp 11, alu_op=ADD. No corrupted instruction from the earlier partial.
- BEAT_W=2, push and pop in the same cycle with lvl=1 → lvl stays 1, and the head changes to the new instruction.
- IDLI_DCD_FLUSH_EN, lvl=2 plus a partial beat, flush pulsed → lvl=0 and vld=0 next cycle. The following BEATS beats decode correctly.
